imm_ext_pipe: RTL and testbench

IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

---
 rtl/imm_ext_pipe.sv | 70 +++++++
 tb/tb_imm_ext_pipe.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/imm_ext_pipe.sv
// Immediate extender with a 2-entry output FIFO: one-cycle latency, and in_ready
// is derived from the registered occupancy only, so out_ready never reaches it.
module imm_ext_pipe #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    localparam int EXT_W = OUT_W - IN_W;

    logic [1:0]       count;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [OUT_W-1:0] mem [2];
    logic [OUT_W-1:0] ext_data;
    logic [OUT_W-1:0] sext_data;
    logic             accept;
    logic             pop;

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Empty buffer reads as zero, so storage needs no reset.
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    assign sext_data = {{EXT_W{in_data[IN_W-1]}}, in_data};

    always_comb begin
        ext_data = '0;
        case (in_mode)
            2'b00:   ext_data = sext_data;
            2'b01:   ext_data = {{EXT_W{1'b0}}, in_data};
            2'b10:   ext_data = {sext_data[OUT_W-3:0], 2'b00};
            default: ext_data = {in_data, {EXT_W{1'b0}}};
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= ext_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe at default widths (IN_W=17, OUT_W=32).
module tb_imm_ext_pipe;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] in_data;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int checks;
    int errors;

    imm_ext_pipe dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [16:0] vec_data [7];
    logic [1:0]  vec_mode [7];
    logic [31:0] vec_exp  [7];
    int          n_acc;

    initial begin
        vec_data[0] = 17'h10000; vec_mode[0] = 2'b00; vec_exp[0] = 32'hFFFF0000;
        vec_data[1] = 17'h10000; vec_mode[1] = 2'b01; vec_exp[1] = 32'h00010000;
        vec_data[2] = 17'h1FFFF; vec_mode[2] = 2'b10; vec_exp[2] = 32'hFFFFFFFC;
        vec_data[3] = 17'h00003; vec_mode[3] = 2'b10; vec_exp[3] = 32'h0000000C;
        vec_data[4] = 17'h00001; vec_mode[4] = 2'b11; vec_exp[4] = 32'h00008000;
        vec_data[5] = 17'h1FFFF; vec_mode[5] = 2'b11; vec_exp[5] = 32'hFFFF8000;
        vec_data[6] = 17'h0FFFF; vec_mode[6] = 2'b00; vec_exp[6] = 32'h0000FFFF;

        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 2'b00;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_data",  out_data,           32'd0);

        // One item per mode vector; visible one edge after accept, then popped.
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = vec_data[i];
            in_mode  = vec_mode[i];
            tick();
            in_valid = 1'b0;
            in_data  = 17'h0AAAA;
            in_mode  = 2'b01;
            chk($sformatf("mode_valid%0d", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("mode_data%0d", i),  out_data,           vec_exp[i]);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk($sformatf("mode_empty%0d", i), {31'd0, out_valid}, 32'd0);
        end

        // Backpressure: three offers with out_ready low, only two fit.
        n_acc = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            case (i)
                0:       begin in_data = 17'h00005; in_mode = 2'b01; end
                1:       begin in_data = 17'h1FFFE; in_mode = 2'b00; end
                default: begin in_data = 17'h00001; in_mode = 2'b11; end
            endcase
            if (in_ready) n_acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_accepted",  n_acc,              32'd2);
        chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
        chk("bp_head",      out_data,           32'h00000005);
        tick();
        chk("bp_hold_data", out_data,           32'h00000005);
        chk("bp_hold_vld",  {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        #1;
        chk("bp_pop_rdy_low", {31'd0, in_ready}, 32'd0);
        tick();
        chk("bp_rdy_rise",  {31'd0, in_ready},  32'd1);
        chk("bp_second",    out_data,           32'hFFFFFFFE);
        tick();
        chk("bp_drained",   {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Streaming: accept and pop every cycle, occupancy stays at one.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 17'(i * 3 + 1);
            in_mode  = 2'b01;
            tick();
            chk($sformatf("st_data%0d", i),  out_data,          32'(i * 3 + 1));
            chk($sformatf("st_ready%0d", i), {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("st_drained", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Reset with a full buffer and a live offer.
        in_valid = 1'b1;
        in_data  = 17'h00011; in_mode = 2'b01;
        tick();
        in_data  = 17'h00022;
        tick();
        chk("mr_full", {31'd0, in_ready}, 32'd0);
        reset    = 1'b1;
        in_data  = 17'h00033;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_in_ready",  {31'd0, in_ready},  32'd1);
        chk("mr_out_data",  out_data,           32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mr_no_stale%0d", i), {31'd0, out_valid}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
